// File: rtl/bit_calc_seq.sv
// Multi-nibble sequencer for the 4-bit bit-logic unit: streams latched operands LSB nibble
// first, gathers the result nibbles and folds the unit's per-nibble flag into a word flag.
module bit_calc_seq #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   START,
    input  logic [1:0]             OP,
    input  logic [4*NIBBLES-1:0]   A,
    input  logic [4*NIBBLES-1:0]   B,
    output logic                   BUSY,
    output logic                   DONE,
    output logic [4*NIBBLES-1:0]   RESULT,
    output logic                   FLAG,
    output logic [3:0]             BC_IN1,
    output logic [3:0]             BC_IN2,
    output logic [1:0]             BC_SEL,
    input  logic [3:0]             BC_OUT,
    output logic                   BC_FLG_IN,
    input  logic                   BC_FLG_OUT
);

    localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e                    state_q;
    logic [NIBBLES-1:0][3:0]   a_q;
    logic [NIBBLES-1:0][3:0]   b_q;
    logic [NIBBLES-1:0][3:0]   work_q;
    logic [NIBBLES-1:0][3:0]   work_d;
    logic [NIBBLES-1:0][3:0]   result_q;
    logic [1:0]                op_q;
    logic [IdxW-1:0]           idx_q;
    logic                      zacc_q;
    logic                      flag_q;
    logic                      flag_d;
    logic                      done_q;
    logic [3:0]                nib_a;
    logic [3:0]                nib_b;
    logic                      in_run;

    // Select the current operand nibbles and merge the unit result into the work word.
    always_comb begin
        nib_a  = '0;
        nib_b  = '0;
        work_d = work_q;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx_q == IdxW'(i)) begin
                nib_a     = a_q[i];
                nib_b     = b_q[i];
                work_d[i] = BC_OUT;
            end
        end
    end

    // Pass keeps the flag, OR sets it, AND/XOR report an all-zero result.
    always_comb begin
        flag_d = flag_q;
        case (op_q)
            2'b00:   flag_d = flag_q;
            2'b01:   flag_d = 1'b1;
            default: flag_d = zacc_q & BC_FLG_OUT;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 2'b00;
            idx_q    <= '0;
            zacc_q   <= 1'b0;
            work_q   <= '0;
            result_q <= '0;
            flag_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (START) begin
                        a_q     <= A;
                        b_q     <= B;
                        op_q    <= OP;
                        idx_q   <= '0;
                        zacc_q  <= 1'b1;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    work_q <= work_d;
                    if (op_q[1]) begin
                        zacc_q <= zacc_q & BC_FLG_OUT;
                    end
                    if (idx_q == LastIdx) begin
                        result_q <= work_d;
                        flag_q   <= flag_d;
                        done_q   <= 1'b1;
                        state_q  <= StDone;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign in_run    = (state_q == StRun);
    assign BUSY      = (state_q != StIdle);
    assign DONE      = done_q;
    assign RESULT    = result_q;
    assign FLAG      = flag_q;
    assign BC_IN1    = in_run ? nib_a : 4'h0;
    assign BC_IN2    = in_run ? nib_b : 4'h0;
    assign BC_SEL    = in_run ? op_q : 2'b00;
    assign BC_FLG_IN = flag_q;

endmodule

// File: tb/tb_bit_calc_seq.sv
// Bench for bit_calc_seq: directed vector table on a 4-nibble instance, multi-cycle corner
// sequences, and a randomised sweep of 1- and 8-nibble instances against a word model.
module tb_bit_calc_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Bit-logic unit model; pass and OR flag outputs are deliberately unhelpful.
    function automatic logic [3:0] unit_out(input logic [1:0] sel, input logic [3:0] x,
                                            input logic [3:0] y);
        case (sel)
            2'b00:   return y;
            2'b01:   return x | y;
            2'b10:   return x & y;
            default: return x ^ y;
        endcase
    endfunction

    function automatic logic unit_flg(input logic [1:0] sel, input logic [3:0] r,
                                      input logic fin);
        case (sel)
            2'b00:   return ~fin;
            2'b01:   return (r != 4'h0);
            default: return (r == 4'h0);
        endcase
    endfunction

    function automatic logic [31:0] ref_op(input logic [1:0] o, input logic [31:0] x,
                                           input logic [31:0] y);
        case (o)
            2'b00:   return y;
            2'b01:   return x | y;
            2'b10:   return x & y;
            default: return x ^ y;
        endcase
    endfunction

    logic rst;

    // 4-nibble instance
    logic start, busy, done, flag, bc_flg_in, bc_flg_out;
    logic [1:0] op, bc_sel;
    logic [15:0] a, b, result;
    logic [3:0] bc_in1, bc_in2, bc_out;
    assign bc_out     = unit_out(bc_sel, bc_in1, bc_in2);
    assign bc_flg_out = unit_flg(bc_sel, bc_out, bc_flg_in);

    bit_calc_seq #(.NIBBLES(4)) u_dut (
        .CLK(clk), .RESET(rst), .START(start), .OP(op), .A(a), .B(b),
        .BUSY(busy), .DONE(done), .RESULT(result), .FLAG(flag),
        .BC_IN1(bc_in1), .BC_IN2(bc_in2), .BC_SEL(bc_sel), .BC_OUT(bc_out),
        .BC_FLG_IN(bc_flg_in), .BC_FLG_OUT(bc_flg_out)
    );

    // 1-nibble instance
    logic s1_start, s1_busy, s1_done, s1_flag, s1_fin, s1_fout;
    logic [1:0] s1_op, s1_sel;
    logic [3:0] s1_a, s1_b, s1_result, s1_in1, s1_in2, s1_out;
    assign s1_out  = unit_out(s1_sel, s1_in1, s1_in2);
    assign s1_fout = unit_flg(s1_sel, s1_out, s1_fin);

    bit_calc_seq #(.NIBBLES(1)) u_dut1 (
        .CLK(clk), .RESET(rst), .START(s1_start), .OP(s1_op), .A(s1_a), .B(s1_b),
        .BUSY(s1_busy), .DONE(s1_done), .RESULT(s1_result), .FLAG(s1_flag),
        .BC_IN1(s1_in1), .BC_IN2(s1_in2), .BC_SEL(s1_sel), .BC_OUT(s1_out),
        .BC_FLG_IN(s1_fin), .BC_FLG_OUT(s1_fout)
    );

    // 8-nibble instance
    logic s8_start, s8_busy, s8_done, s8_flag, s8_fin, s8_fout;
    logic [1:0] s8_op, s8_sel;
    logic [31:0] s8_a, s8_b, s8_result;
    logic [3:0] s8_in1, s8_in2, s8_out;
    assign s8_out  = unit_out(s8_sel, s8_in1, s8_in2);
    assign s8_fout = unit_flg(s8_sel, s8_out, s8_fin);

    bit_calc_seq #(.NIBBLES(8)) u_dut8 (
        .CLK(clk), .RESET(rst), .START(s8_start), .OP(s8_op), .A(s8_a), .B(s8_b),
        .BUSY(s8_busy), .DONE(s8_done), .RESULT(s8_result), .FLAG(s8_flag),
        .BC_IN1(s8_in1), .BC_IN2(s8_in2), .BC_SEL(s8_sel), .BC_OUT(s8_out),
        .BC_FLG_IN(s8_fin), .BC_FLG_OUT(s8_fout)
    );

    logic [15:0] m_result;
    logic        m_flag;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_r;
        logic        exp_f;
    } vec_t;

    vec_t vecs[12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                          input logic [15:0] er, input logic ef);
        check("idle_busy", busy, 0);
        check("idle_sel", bc_sel, 0);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        tick();
        start = 1'b0;
        a     = ~x;
        b     = ~y;
        op    = ~o;
        for (int i = 0; i < 4; i++) begin
            check("run_busy", busy, 1);
            check("run_done", done, 0);
            check("run_in1", bc_in1, x[4*i +: 4]);
            check("run_in2", bc_in2, y[4*i +: 4]);
            check("run_sel", bc_sel, o);
            check("run_result_stable", result, m_result);
            check("run_flag_stable", flag, m_flag);
            check("run_flg_in", bc_flg_in, m_flag);
            tick();
        end
        check("done_pulse", done, 1);
        check("done_busy", busy, 1);
        check("done_result", result, er);
        check("done_flag", flag, ef);
        check("done_flg_in", bc_flg_in, ef);
        check("done_sel", bc_sel, 0);
        check("done_in1", bc_in1, 0);
        check("done_in2", bc_in2, 0);
        m_result = er;
        m_flag   = ef;
        tick();
        check("after_done", done, 0);
        check("after_busy", busy, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not end, expected completion");
        $fatal(1);
    end

    initial begin
        logic [1:0]  o1, o8;
        logic [3:0]  a1, b1, r1;
        logic [31:0] a8, b8, r8;
        logic        f1, f8;
        int          lat1, lat8, p1, p8;
        logic        saw_done;

        vecs[0]  = '{2'b10, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0};
        vecs[1]  = '{2'b11, 16'h1234, 16'h1234, 16'h0000, 1'b1};
        vecs[2]  = '{2'b11, 16'h1234, 16'h1230, 16'h0004, 1'b0};
        vecs[3]  = '{2'b01, 16'h0000, 16'h0000, 16'h0000, 1'b1};
        vecs[4]  = '{2'b00, 16'h1234, 16'hBEEF, 16'hBEEF, 1'b1};
        vecs[5]  = '{2'b10, 16'h0001, 16'h0001, 16'h0001, 1'b0};
        vecs[6]  = '{2'b00, 16'hFFFF, 16'h0000, 16'h0000, 1'b0};
        vecs[7]  = '{2'b01, 16'h00A0, 16'h0B00, 16'h0BA0, 1'b1};
        vecs[8]  = '{2'b00, 16'h5555, 16'h0000, 16'h0000, 1'b1};
        vecs[9]  = '{2'b11, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1};
        vecs[10] = '{2'b10, 16'h8000, 16'h8000, 16'h8000, 1'b0};
        vecs[11] = '{2'b10, 16'hFFFF, 16'h0000, 16'h0000, 1'b1};

        rst = 1'b1;
        start = 1'b0; op = 2'b00; a = '0; b = '0;
        s1_start = 1'b0; s1_op = 2'b00; s1_a = '0; s1_b = '0;
        s8_start = 1'b0; s8_op = 2'b00; s8_a = '0; s8_b = '0;
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_flag", flag, 0);
        check("rst_sel", bc_sel, 0);
        check("rst_in1", bc_in1, 0);
        check("rst_in2", bc_in2, 0);
        check("rst_flg_in", bc_flg_in, 0);
        rst = 1'b0;
        m_result = '0;
        m_flag   = 1'b0;
        tick();

        for (int v = 0; v < 12; v++) begin
            run_op(vecs[v].op, vecs[v].a, vecs[v].b, vecs[v].exp_r, vecs[v].exp_f);
        end

        // START held through a whole operation and its DONE cycle.
        start = 1'b1; op = 2'b11; a = 16'h00FF; b = 16'h0F0F;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c == 1) begin
                a = 16'h1111;
                b = 16'h1111;
            end
            check("held_busy", busy, (c != 6 && c != 12) ? 1 : 0);
            check("held_done", done, (c == 5 || c == 11) ? 1 : 0);
            if (c == 5) begin
                check("held_result1", result, 16'h0FF0);
                check("held_flag1", flag, 0);
            end
            if (c == 11) begin
                check("held_result2", result, 16'h0000);
                check("held_flag2", flag, 1);
            end
            if (c == 12) start = 1'b0;
        end
        tick();
        check("held_released", busy, 0);
        m_result = 16'h0000;
        m_flag   = 1'b1;

        // Reset in the second RUN cycle aborts the operation.
        run_op(2'b01, 16'h1234, 16'h0000, 16'h1234, 1'b1);
        start = 1'b1; op = 2'b10; a = 16'hFFFF; b = 16'hFFFF;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        check("abort_pre_result", result, 16'h1234);
        tick();
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_result", result, 0);
        check("abort_flag", flag, 0);
        m_result = '0;
        m_flag   = 1'b0;
        saw_done = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (done || busy) saw_done = 1'b1;
        end
        check("abort_no_done", saw_done, 0);
        run_op(2'b11, 16'h00FF, 16'h0F0F, 16'h0FF0, 1'b0);

        // Randomised sweep of the 1- and 8-nibble instances, run in lockstep.
        f1 = 1'b0;
        f8 = 1'b0;
        for (int n = 0; n < 200; n++) begin
            o1 = 2'($urandom_range(0, 3));
            o8 = 2'($urandom_range(0, 3));
            a1 = 4'($urandom());
            b1 = 4'($urandom());
            a8 = $urandom();
            b8 = $urandom();
            if ($urandom_range(0, 3) == 0) b1 = a1;
            if ($urandom_range(0, 3) == 0) b8 = a8;
            if ($urandom_range(0, 7) == 0) begin
                a8 = '0;
                b8 = '0;
            end
            r1 = 4'(ref_op(o1, {28'h0, a1}, {28'h0, b1}));
            r8 = ref_op(o8, a8, b8);
            if (o1 == 2'b01) f1 = 1'b1;
            else if (o1[1]) f1 = (r1 == 4'h0);
            if (o8 == 2'b01) f8 = 1'b1;
            else if (o8[1]) f8 = (r8 == 32'h0);

            s1_start = 1'b1; s1_op = o1; s1_a = a1; s1_b = b1;
            s8_start = 1'b1; s8_op = o8; s8_a = a8; s8_b = b8;
            lat1 = 0; lat8 = 0; p1 = 0; p8 = 0;
            for (int c = 1; c <= 12; c++) begin
                tick();
                if (c == 1) begin
                    s1_start = 1'b0; s1_a = ~a1; s1_b = ~b1; s1_op = ~o1;
                    s8_start = 1'b0; s8_a = ~a8; s8_b = ~b8; s8_op = ~o8;
                    check("sweep1_busy", s1_busy, 1);
                    check("sweep8_busy", s8_busy, 1);
                end
                if (s1_done) begin
                    p1++;
                    if (lat1 == 0) lat1 = c;
                end
                if (s8_done) begin
                    p8++;
                    if (lat8 == 0) lat8 = c;
                    check("sweep8_result", s8_result, r8);
                    check("sweep8_flag", s8_flag, f8);
                end
                if (c == 2 && s1_done) begin
                    check("sweep1_result", s1_result, r1);
                    check("sweep1_flag", s1_flag, f1);
                end
            end
            check("sweep1_latency", lat1, 2);
            check("sweep8_latency", lat8, 9);
            check("sweep1_pulses", p1, 1);
            check("sweep8_pulses", p8, 1);
            check("sweep1_final_result", s1_result, r1);
            check("sweep8_final_flag", s8_flag, f8);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
